// File: rtl/pipelined_quant_divider.sv
// Pipelined signed-by-unsigned divider for the quantisation stage.
// Restoring long division, BITS_PER_STAGE quotient bits per stage.
module pipelined_quant_divider #(
  parameter int DIVIDEND_LEN   = 16,
  parameter int DIVISOR_LEN    = 8,
  parameter int TAG_LEN        = 8,
  parameter int BITS_PER_STAGE = 2,
  parameter int ROUND_MODE     = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DIVIDEND_LEN-1:0] dividend,
  input  logic [DIVISOR_LEN-1:0]  divisor,
  input  logic [TAG_LEN-1:0]      tag,
  input  logic                    input_valid,
  output logic [DIVIDEND_LEN-1:0] quotient,
  output logic [TAG_LEN-1:0]      tag_out,
  output logic                    div_by_zero,
  output logic                    output_valid
);

  localparam int DL = DIVIDEND_LEN;
  localparam int DV = DIVISOR_LEN;
  localparam int S  = DIVIDEND_LEN / BITS_PER_STAGE;

  generate
    if (DIVIDEND_LEN % BITS_PER_STAGE != 0) begin : g_bad_split
      $error("BITS_PER_STAGE must divide DIVIDEND_LEN");
    end
  endgenerate

  logic [DV:0]        rem_q [0:S];
  logic [DL-1:0]      num_q [0:S];
  logic [DV-1:0]      dsr_q [0:S];
  logic [TAG_LEN-1:0] tag_q [0:S];
  logic [S:0]         neg_q;
  logic [S:0]         zero_q;
  logic [S:0]         vld_q;

  logic [DL-1:0] mag_in;
  logic [DL-1:0] mag_fin;
  logic [DL-1:0] q_fin;
  logic          rnd_up;

  // num shifts left each bit: dividend bits leave the top,
  // quotient bits enter at the bottom
  function automatic logic [DV+DL:0] div_step(
    input logic [DV:0]   r_in,
    input logic [DL-1:0] n_in,
    input logic [DV-1:0] d
  );
    logic [DV+1:0] t;
    logic [DV:0]   r;
    logic [DL-1:0] n;
    r = r_in;
    n = n_in;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      t = {r, n[DL-1]};
      n = n << 1;
      if (t >= {2'b00, d}) begin
        t    = t - {2'b00, d};
        n[0] = 1'b1;
      end
      r = t[DV:0];
    end
    return {r, n};
  endfunction

  assign mag_in = dividend[DL-1] ? (~dividend + 1'b1)
                                 : dividend;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
    end else if (enable) begin
      rem_q[0]  <= '0;
      num_q[0]  <= mag_in;
      dsr_q[0]  <= divisor;
      tag_q[0]  <= tag;
      neg_q[0]  <= dividend[DL-1];
      zero_q[0] <= (divisor == '0);
      vld_q[0]  <= input_valid;
      for (int i = 1; i <= S; i++) begin
        {rem_q[i], num_q[i]} <=
          div_step(rem_q[i-1], num_q[i-1], dsr_q[i-1]);
        dsr_q[i]  <= dsr_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        neg_q[i]  <= neg_q[i-1];
        zero_q[i] <= zero_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  always_comb begin
    rnd_up  = (ROUND_MODE == 1) &&
              ({rem_q[S], 1'b0} >= {2'b00, dsr_q[S]});
    mag_fin = num_q[S] + {{(DL-1){1'b0}}, rnd_up};
    q_fin   = neg_q[S] ? (~mag_fin + 1'b1) : mag_fin;
    if (zero_q[S]) begin
      q_fin = neg_q[S] ? {1'b1, {(DL-1){1'b0}}}
                       : {1'b0, {(DL-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quotient     <= '0;
      tag_out      <= '0;
      div_by_zero  <= 1'b0;
      output_valid <= 1'b0;
    end else if (enable) begin
      quotient     <= q_fin;
      tag_out      <= tag_q[S];
      div_by_zero  <= vld_q[S] & zero_q[S];
      output_valid <= vld_q[S];
    end
  end

endmodule

// File: tb/tb_pipelined_quant_divider.sv
// Bench for pipelined_quant_divider: directed vectors, reset,
// and a stalled random stream against an arithmetic model.
module tb_pipelined_quant_divider;

  typedef struct packed {
    logic        v;
    logic [15:0] q;
    logic [7:0]  t;
    logic        z;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, input_valid;
  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic [11:0] dvd12;
  logic [5:0]  dvs6;
  logic [7:0]  tag;

  logic [15:0] q_a, q_b;
  logic [11:0] q_c, q_d;
  logic [7:0]  t_a, t_b, t_c, t_d;
  logic        ov_a, ov_b, ov_c, ov_d;
  logic        dz_a, dz_b, dz_c, dz_d;

  int checks = 0;
  int errors = 0;

  exp_t pipe [4][$];
  exp_t cur  [4];
  int   lat  [4] = '{9, 9, 13, 4};
  int   dl   [4] = '{16, 16, 12, 12};
  bit   rnd  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  pipelined_quant_divider #(.ROUND_MODE(0)) u_trunc (
    .clock(clock), .reset(reset), .enable(enable),
    .dividend(dvd), .divisor(dvs), .tag(tag),
    .input_valid(input_valid), .quotient(q_a),
    .tag_out(t_a), .div_by_zero(dz_a), .output_valid(ov_a));

  pipelined_quant_divider #(.ROUND_MODE(1)) u_round (
    .clock(clock), .reset(reset), .enable(enable),
    .dividend(dvd), .divisor(dvs), .tag(tag),
    .input_valid(input_valid), .quotient(q_b),
    .tag_out(t_b), .div_by_zero(dz_b), .output_valid(ov_b));

  pipelined_quant_divider #(
    .DIVIDEND_LEN(12), .DIVISOR_LEN(6),
    .BITS_PER_STAGE(1), .ROUND_MODE(0)
  ) u_s1 (
    .clock(clock), .reset(reset), .enable(enable),
    .dividend(dvd12), .divisor(dvs6), .tag(tag),
    .input_valid(input_valid), .quotient(q_c),
    .tag_out(t_c), .div_by_zero(dz_c), .output_valid(ov_c));

  pipelined_quant_divider #(
    .DIVIDEND_LEN(12), .DIVISOR_LEN(6),
    .BITS_PER_STAGE(4), .ROUND_MODE(1)
  ) u_s4 (
    .clock(clock), .reset(reset), .enable(enable),
    .dividend(dvd12), .divisor(dvs6), .tag(tag),
    .input_valid(input_valid), .quotient(q_d),
    .tag_out(t_d), .div_by_zero(dz_d), .output_valid(ov_d));

  task automatic chk(input string name,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Integer reference straight from the arithmetic definition
  function automatic int ref_div(int n, int d, bit r, int w);
    int mag;
    if (d == 0) return (n >= 0) ? (1 << (w - 1)) - 1 : -(1 << (w - 1));
    if (!r) return n / d;
    mag = ((n < 0 ? -n : n) + d / 2) / d;
    return (n < 0) ? -mag : mag;
  endfunction

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [15:0] n, input logic [7:0] d,
                      input logic [11:0] n12, input logic [5:0] d6,
                      input logic [7:0] t);
    exp_t        x;
    int          nn, dd, qq;
    logic        ov [4];
    logic [15:0] oq [4];
    logic [7:0]  ot [4];
    logic        oz [4];
    reset = r; enable = e; input_valid = v;
    dvd = n; dvs = d; dvd12 = n12; dvs6 = d6; tag = t;
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        pipe[i].delete();
        cur[i] = '0;
      end else if (e) begin
        nn = (i < 2) ? int'($signed(n)) : int'($signed(n12));
        dd = (i < 2) ? int'(d) : int'(d6);
        qq = ref_div(nn, dd, rnd[i], dl[i]);
        x.v = v;
        x.t = t;
        x.z = v && (dd == 0);
        x.q = 16'(qq & ((1 << dl[i]) - 1));
        pipe[i].push_back(x);
        if (pipe[i].size() > lat[i]) cur[i] = pipe[i].pop_front();
        else begin
          cur[i].v = 1'b0;
          cur[i].z = 1'b0;
        end
      end
    end
    #1;
    ov = '{ov_a, ov_b, ov_c, ov_d};
    oq = '{q_a, q_b, {4'b0, q_c}, {4'b0, q_d}};
    ot = '{t_a, t_b, t_c, t_d};
    oz = '{dz_a, dz_b, dz_c, dz_d};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_valid", i), 32'(ov[i]), 32'(cur[i].v));
      chk($sformatf("u%0d_dbz", i), 32'(oz[i]), 32'(cur[i].z));
      if (cur[i].v || r) begin
        chk($sformatf("u%0d_quot", i), 32'(oq[i]), 32'(cur[i].q));
        chk($sformatf("u%0d_tag", i), 32'(ot[i]), 32'(cur[i].t));
      end
    end
  endtask

  task automatic rnd_step(input bit v, input bit e, input logic [7:0] t);
    logic [15:0] n;
    logic [7:0]  d;
    logic [11:0] n12;
    logic [5:0]  d6;
    n   = 16'($urandom);
    n12 = 12'($urandom);
    d   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
    d6  = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom);
    case ($urandom_range(0, 9))
      0: begin n = 16'h8000; n12 = 12'h800; end
      1: begin n = 16'h7FFF; n12 = 12'h7FF; end
      default: ;
    endcase
    step(1'b0, e, v, n, d, n12, d6, t);
  endtask

  task automatic dir(input logic [15:0] n, input logic [7:0] d,
                     input logic [15:0] qt, input logic [15:0] qr,
                     input bit z, input logic [7:0] t);
    step(1'b0, 1'b1, 1'b1, n, d, 12'($urandom), 6'($urandom), t);
    for (int k = 1; k <= 9; k++) begin
      rnd_step(1'b0, 1'b1, 8'h00);
      if (k < 9) chk("dir_early", 32'(ov_a), 32'd0);
    end
    chk("dir_valid", 32'(ov_a), 32'd1);
    chk("dir_trunc", 32'(q_a), 32'(qt));
    chk("dir_round", 32'(q_b), 32'(qr));
    chk("dir_tag", 32'(t_a), 32'(t));
    chk("dir_dbz", 32'(dz_a), 32'(z));
  endtask

  initial begin
    int accepted;
    int cyc;
    bit v, e;
    step(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, '0);

    dir(16'd100,     8'd7,   16'd14,     16'd14,     1'b0, 8'h01);
    dir(16'd100,     8'd1,   16'd100,    16'd100,    1'b0, 8'h02);
    dir(16'd0,       8'd255, 16'd0,      16'd0,      1'b0, 8'h03);
    dir(16'd32767,   8'd255, 16'd128,    16'd128,    1'b0, 8'h04);
    dir(-16'sd100,   8'd8,   -16'sd12,   -16'sd13,   1'b0, 8'h05);
    dir(16'd100,     8'd8,   16'd12,     16'd13,     1'b0, 8'h06);
    dir(16'd99,      8'd8,   16'd12,     16'd12,     1'b0, 8'h07);
    dir(16'h8000,    8'd1,   16'h8000,   16'h8000,   1'b0, 8'h08);
    dir(-16'sd7,     8'd2,   -16'sd3,    -16'sd4,    1'b0, 8'h09);
    dir(16'd5,       8'd0,   16'h7FFF,   16'h7FFF,   1'b1, 8'h0A);
    dir(-16'sd5,     8'd0,   16'h8000,   16'h8000,   1'b1, 8'h0B);
    dir(16'd6,       8'd3,   16'd2,      16'd2,      1'b0, 8'h0C);

    for (int k = 0; k < 10; k++) rnd_step(1'b1, 1'b1, 8'(k + 16));
    step(1'b1, 1'b0, 1'b1, 16'd1, 8'd1, 12'd1, 6'd1, 8'hEE);
    chk("rst_quot", 32'(q_a), 32'd0);
    chk("rst_tag", 32'(t_a), 32'd0);
    chk("rst_valid", 32'(ov_a), 32'd0);
    chk("rst_dbz", 32'(dz_a), 32'd0);
    step(1'b0, 1'b1, 1'b1, 16'd50, 8'd5, 12'd50, 6'd5, 8'hA5);
    for (int k = 1; k <= 9; k++) begin
      rnd_step(1'b0, 1'b1, 8'h00);
      if (k < 9) chk("rst_old_word", 32'(ov_a), 32'd0);
    end
    chk("rst_new_valid", 32'(ov_a), 32'd1);
    chk("rst_new_tag", 32'(t_a), 32'hA5);
    chk("rst_new_quot", 32'(q_a), 32'd10);

    accepted = 0;
    cyc = 0;
    while (accepted < 2000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 4) != 0);
      rnd_step(v, e, 8'(accepted));
      if (v && e) accepted++;
      cyc++;
    end
    chk("stream_accepted", 32'(accepted), 32'd2000);
    for (int k = 0; k < 20; k++) rnd_step(1'b0, 1'b1, 8'h00);
    chk("stream_drained_valid", 32'(ov_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_quant_divider.md
# pipelined_quant_divider

Fully pipelined signed-by-unsigned integer divider: a parametrised, synthesisable replacement for the behavioural divider stand-in used in the quantisation stage. It accepts one dividend/divisor pair per cycle and returns the quotient a fixed number of cycles later. The quotient is either truncated toward zero or rounded half away from zero, selected by parameter. A tag travels with each pair, divide-by-zero is flagged, and a global enable stalls the whole pipeline. It sits between the DCT output and the entropy coder, dividing DCT coefficients by quantisation-table entries.

## Interface
Parameters:
- DIVIDEND_LEN, 16, dividend and quotient width, two's complement
- DIVISOR_LEN, 8, divisor width, unsigned
- TAG_LEN, 8, width of the pass-through tag
- BITS_PER_STAGE, 2, quotient bits resolved per pipeline stage; must divide DIVIDEND_LEN exactly (elaboration error otherwise)
- ROUND_MODE, 0: 0 = truncate toward zero (Verilog `/` semantics); 1 = round half away from zero

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- enable  in  1  1 = pipeline advances; 0 = every stage register holds
- dividend  in  DIVIDEND_LEN  signed numerator
- divisor  in  DIVISOR_LEN  unsigned denominator
- tag  in  TAG_LEN  opaque identifier, returned unchanged with the result
- input_valid  in  1  marks the dividend/divisor/tag word as valid
- quotient  out  DIVIDEND_LEN  signed result
- tag_out  out  TAG_LEN  tag belonging to quotient
- div_by_zero  out  1  result was produced from divisor == 0
- output_valid  out  1  quotient, tag_out and div_by_zero are valid

## Operation
- Define S = DIVIDEND_LEN / BITS_PER_STAGE. The pipeline is S+2 register stages.
- Stage 0 (input register):
  - Capture |dividend| as a DIVIDEND_LEN-bit unsigned value, so that -2^(DIVIDEND_LEN-1) maps to 2^(DIVIDEND_LEN-1).
  - Capture the dividend sign bit, divisor, tag, valid, and a zero flag (divisor == 0).
- Stages 1..S (non-restoring or restoring long division, implementer's choice):
  - Each stage resolves BITS_PER_STAGE quotient bits, MSB first.
  - The partial remainder is DIVISOR_LEN+1 bits wide.
  - Divisor, sign, zero flag, tag and valid are carried alongside each stage.
- Stage S+1 (output register), given magnitude m and final remainder r:
  - ROUND_MODE = 1 and 2·r ≥ divisor: m ← m+1. Overflow cannot occur; no saturation logic is needed.
  - Sign bit set: quotient = −m; otherwise quotient = m.
  - Zero flag set: quotient = 2^(DIVIDEND_LEN-1)−1 if the dividend was ≥ 0, else −2^(DIVIDEND_LEN-1); div_by_zero = 1. The rounding step is ignored.
- Invalid words (input_valid = 0) flow through as bubbles. Their data fields are don't-care, but output_valid is 0 and div_by_zero is 0.
- The result must be bit-exact with the integer reference for every input combination:
  - Truncate mode: trunc(n/d).
  - Round mode: sign(n)·floor((|n| + floor(d/2)) / d).

## Timing
- Latency: a word sampled with input_valid = 1 on enabled edge k appears at the outputs after enabled edge k+S+1. With defaults that is 10 enabled edges.
- Throughput: one word per enabled cycle; no back-to-back restriction.
- enable = 0:
  - No register changes. Outputs, output_valid included, hold their last values.
  - Inputs presented during that cycle are ignored. The producer must hold the word or re-present it.
  - A held output_valid = 1 refers to the same word; the consumer must qualify its capture with enable.
- Reset (synchronous):
  - All stage valids clear.
  - quotient = 0, tag_out = 0, div_by_zero = 0, output_valid = 0 on the first edge with reset = 1.
  - Reset overrides enable.
  - Words in flight when reset asserts are discarded; no partial result ever emerges.
  - The first word accepted after reset deasserts follows normal latency.
- Simultaneous enable = 0 and reset = 1: the reset behaviour applies.

## Test plan
- Truncate, defaults: 100/7, 100/1, 0/255, 32767/255 -> 14, 100, 0, 128. Each appears exactly 10 enabled edges after input, with output_valid = 1 and matching tag_out.
- Signed/rounding:
  - −100/8 -> −12 with ROUND_MODE = 0, −13 with ROUND_MODE = 1.
  - 100/8 -> 12 / 13 (truncate / round).
  - 99/8 -> 12 / 12.
  - −32768/1 -> −32768 in both modes.
  - −7/2 -> −3 / −4.
- Divide by zero: 5/0 -> 32767 with div_by_zero = 1; −5/0 -> −32768 with div_by_zero = 1. The next word, 6/3, -> 2 with div_by_zero = 0.
- Streaming with stalls:
  - Stimulus: 2000 random pairs with random input_valid gaps and random enable deassertion (~20%), tags = sequence number.
  - Response: outputs match the scoreboard model in order, with no drops or duplicates, and output_valid is held across every enable = 0 cycle.
- Reset mid-stream:
  - Fill the pipeline with 10 valid words, assert reset for 1 cycle, then send 1 new word with tag 0xA5.
  - Response: all outputs are 0 immediately after reset. No old word appears. Tag 0xA5 emerges 10 edges later.
- Parameter sweep: rerun the random stream for BITS_PER_STAGE ∈ {1,4}, DIVIDEND_LEN = 12, DIVISOR_LEN = 6. Latency must equal DIVIDEND_LEN/BITS_PER_STAGE + 2, and results must be bit-exact.
